// File: rtl/bt656_pkg.sv
// rtl/bt656_pkg.sv - BT.656 shared types, code constants, XY encoder, clamp and colour-bar table
package bt656_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EAV,
    ST_HBLANK,
    ST_SAV,
    ST_ACTIVE
  } state_t;

  localparam logic [7:0] PREAMBLE_FF  = 8'hFF;
  localparam logic [7:0] PREAMBLE_00  = 8'h00;
  localparam logic [7:0] BLANK_CHROMA = 8'h80;
  localparam logic [7:0] BLANK_LUMA   = 8'h10;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycbcr_t;

  // 75% colour bars: white, yellow, cyan, green, magenta, red, blue, black
  localparam ycbcr_t COLOR_BARS [8] = '{
    '{y: 8'hB4, cb: 8'h80, cr: 8'h80},
    '{y: 8'hA2, cb: 8'h2C, cr: 8'h8E},
    '{y: 8'h83, cb: 8'h9C, cr: 8'h2C},
    '{y: 8'h70, cb: 8'h48, cr: 8'h3A},
    '{y: 8'h54, cb: 8'hB8, cr: 8'hC6},
    '{y: 8'h41, cb: 8'h64, cr: 8'hD4},
    '{y: 8'h23, cb: 8'hD4, cr: 8'h72},
    '{y: 8'h10, cb: 8'h80, cr: 8'h80}
  };

  function automatic logic [7:0] xy_encode(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // 0x00 and 0xFF are reserved for timing references and must never leave as video
  function automatic logic [7:0] clamp_byte(input logic [7:0] b);
    if (b == 8'h00) return 8'h01;
    if (b == 8'hFF) return 8'hFE;
    return b;
  endfunction

endpackage

// File: rtl/bt656_tx_timing.sv
// rtl/bt656_tx_timing.sv - BT.656 line/frame sequencer: byte and line counters plus the line FSM
module bt656_tx_timing
  import bt656_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_enable_i,
  input  logic [10:0] line_len_i,
  input  logic [10:0] frame_lines_i,
  input  logic [7:0]  vblank_lines_i,
  input  logic [7:0]  hblank_len_i,
  output state_t      state_o,
  output logic [1:0]  byte_phase_o,
  output logic        vblank_o,
  output logic        frame_done_o
`ifdef BT656_TX_PATTERN_EN
  ,
  output logic [10:0] line_len_o
`endif
);

  state_t      state, state_n;
  logic [10:0] byte_cnt, byte_n;
  logic [11:0] line_cnt, line_n;
  logic [10:0] line_len_q, frame_lines_q;
  logic [7:0]  vblank_q, hblank_q;
  logic        load;
  logic [11:0] last_line;

  assign last_line    = 12'(frame_lines_q) + 12'(vblank_q) - 12'd1;
  assign state_o      = state;
  assign byte_phase_o = byte_cnt[1:0];
  assign vblank_o     = line_cnt < 12'(vblank_q);
`ifdef BT656_TX_PATTERN_EN
  assign line_len_o   = line_len_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      byte_cnt      <= '0;
      line_cnt      <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      vblank_q      <= '0;
      hblank_q      <= '0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_n;
      line_cnt <= line_n;
      if (load) begin
        line_len_q    <= line_len_i;
        frame_lines_q <= frame_lines_i;
        vblank_q      <= vblank_lines_i;
        hblank_q      <= hblank_len_i;
      end
    end
  end

  always_comb begin
    state_n      = state;
    byte_n       = byte_cnt + 11'd1;
    line_n       = line_cnt;
    load         = 1'b0;
    frame_done_o = 1'b0;
    case (state)
      ST_IDLE: begin
        byte_n = '0;
        line_n = '0;
        if (tx_enable_i) begin
          state_n = ST_EAV;
          load    = 1'b1;
        end
      end
      ST_EAV: begin
        if (byte_cnt == 11'd3) begin
          byte_n  = '0;
          state_n = (hblank_q == 8'd0) ? ST_SAV : ST_HBLANK;
        end
      end
      ST_HBLANK: begin
        if (byte_cnt == 11'(hblank_q) - 11'd1) begin
          byte_n  = '0;
          state_n = ST_SAV;
        end
      end
      ST_SAV: begin
        if (byte_cnt == 11'd3) begin
          byte_n  = '0;
          state_n = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (byte_cnt == line_len_q - 11'd1) begin
          byte_n = '0;
          if (line_cnt == last_line) begin
            // Sampling enable here lets a late reassertion roll straight into the next frame
            frame_done_o = 1'b1;
            line_n       = '0;
            if (tx_enable_i) begin
              state_n = ST_EAV;
              load    = 1'b1;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            line_n  = line_cnt + 12'd1;
            state_n = ST_EAV;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/bt656_tx.sv
// rtl/bt656_tx.sv - BT.656 transmitter top: byte mux, clamp, status; BT656_TX_PATTERN_EN adds colour bars
module bt656_tx
  import bt656_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_enable_i,
  input  logic [10:0] line_len_i,
  input  logic [10:0] frame_lines_i,
  input  logic [7:0]  vblank_lines_i,
  input  logic [7:0]  hblank_len_i,
`ifdef BT656_TX_PATTERN_EN
  input  logic        pattern_sel_i,
`endif
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [7:0]  data_o,
  output logic        href_o,
  output logic        vsync_o,
  output logic [31:0] frame_cnt_o,
  output logic        underflow_o,
  input  logic        rst_underflow_i
);

  state_t     state;
  logic [1:0] byte_phase;
  logic       vblank;
  logic       frame_done;
  logic [7:0] byte_n;
  logic       href_n, vsync_n, uf_set;
  logic [7:0] blank_byte;

`ifdef BT656_TX_PATTERN_EN
  logic [10:0] line_len_q;
  logic [10:0] bar_width;
  logic [10:0] bar_pos;
  logic [2:0]  bar_idx;
  ycbcr_t      bar_c;
  logic [7:0]  bar_byte;
`endif

  bt656_tx_timing u_timing (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .tx_enable_i    (tx_enable_i),
    .line_len_i     (line_len_i),
    .frame_lines_i  (frame_lines_i),
    .vblank_lines_i (vblank_lines_i),
    .hblank_len_i   (hblank_len_i),
    .state_o        (state),
    .byte_phase_o   (byte_phase),
    .vblank_o       (vblank),
    .frame_done_o   (frame_done)
`ifdef BT656_TX_PATTERN_EN
    ,
    .line_len_o     (line_len_q)
`endif
  );

`ifdef BT656_TX_PATTERN_EN
  // Bar width is line_len/8 forced even so each bar holds whole Cb/Y or Cr/Y pairs
  assign bar_width = (line_len_q >> 4) << 1;
  assign bar_c     = COLOR_BARS[bar_idx];
  assign bar_byte  = (byte_phase == 2'd0) ? bar_c.cb :
                     (byte_phase == 2'd2) ? bar_c.cr : bar_c.y;

  always_ff @(posedge clk_i) begin
    if (rst_i || state != ST_ACTIVE) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_pos + 11'd1 == bar_width && bar_idx != 3'd7) begin
      bar_pos <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pos <= bar_pos + 11'd1;
    end
  end

  assign s_ready_o = (state == ST_ACTIVE) && !vblank && !pattern_sel_i;
`else
  assign s_ready_o = (state == ST_ACTIVE) && !vblank;
`endif

  assign blank_byte = byte_phase[0] ? BLANK_LUMA : BLANK_CHROMA;

  always_comb begin
    byte_n  = BLANK_CHROMA;
    href_n  = 1'b0;
    vsync_n = vblank;
    uf_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        byte_n  = (data_o == BLANK_CHROMA) ? BLANK_LUMA : BLANK_CHROMA;
        vsync_n = 1'b1;
      end
      ST_EAV, ST_SAV: begin
        case (byte_phase)
          2'd0:    byte_n = PREAMBLE_FF;
          2'd3:    byte_n = xy_encode(1'b0, vblank, state == ST_EAV);
          default: byte_n = PREAMBLE_00;
        endcase
      end
      ST_HBLANK: byte_n = blank_byte;
      ST_ACTIVE: begin
        if (vblank) begin
          byte_n = blank_byte;
        end else begin
          href_n = 1'b1;
`ifdef BT656_TX_PATTERN_EN
          if (pattern_sel_i) byte_n = bar_byte;
          else
`endif
          if (s_valid_i) begin
            byte_n = clamp_byte(s_data_i);
          end else begin
            byte_n = blank_byte;
            uf_set = 1'b1;
          end
        end
      end
      default: byte_n = BLANK_CHROMA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o      <= BLANK_CHROMA;
      href_o      <= 1'b0;
      vsync_o     <= 1'b1;
      frame_cnt_o <= '0;
      underflow_o <= 1'b0;
    end else begin
      data_o  <= byte_n;
      href_o  <= href_n;
      vsync_o <= vsync_n;
      if (frame_done) frame_cnt_o <= frame_cnt_o + 32'd1;
      if (rst_underflow_i) underflow_o <= 1'b0;
      else if (uf_set)     underflow_o <= 1'b1;
    end
  end

endmodule
